// File: rtl/fetch_register_bank.sv
// Register stage that holds the PC, IR, MDR and ALU output for the multicycle core, plus the IR field decode.
// Optional IFETCH_PERF_CNT_EN adds a 32-bit counter of IR loads; without it instr_count is tied to 0.
module fetch_register_bank #(
   parameter int              DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              I_PC_WRITE,
   input  logic              I_BRANCH,
   input  logic [1:0]        I_PC_SRC,
   input  logic              I_IR_WRITE,
   input  logic              I_INSTRUCTION_OR_DATA,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] pc,
   output logic [5:0]        opcode,
   output logic [5:0]        op_function,
   output logic [4:0]        rd,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [DATA_W-1:0] imm_sext,
   output logic [DATA_W-1:0] mdr,
   output logic [DATA_W-1:0] alu_out,
   output logic [31:0]       instr_count
);

   logic [DATA_W-1:0] pc_reg;
   logic [DATA_W-1:0] pc_next;
   logic [31:0]       ir_reg;
   logic [DATA_W-1:0] mdr_reg;
   logic [DATA_W-1:0] alu_out_reg;
   logic              pc_en;

   // BNE: a conditional load is taken only when the operands differ.
   assign pc_en = I_PC_WRITE | (I_BRANCH & ~alu_zero);

   always_comb begin
      pc_next = pc_reg;
      case (I_PC_SRC)
         2'b00:   pc_next = alu_result;
         2'b01:   pc_next = alu_out_reg;
         2'b10:   pc_next = {pc_reg[DATA_W-1:26], ir_reg[25:0]};
         default: pc_next = pc_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg      <= RESET_PC;
         ir_reg      <= '0;
         mdr_reg     <= '0;
         alu_out_reg <= '0;
      end else begin
         if (pc_en) begin
            pc_reg <= pc_next;
         end
         if (I_IR_WRITE) begin
            ir_reg <= mem_rdata[31:0];
         end
         mdr_reg     <= mem_rdata;
         alu_out_reg <= alu_result;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] instr_count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_count_reg <= '0;
      end else if (I_IR_WRITE) begin
         instr_count_reg <= instr_count_reg + 32'd1;
      end
   end

   assign instr_count = instr_count_reg;
`else
   assign instr_count = '0;
`endif

   assign pc          = pc_reg;
   assign mdr         = mdr_reg;
   assign alu_out     = alu_out_reg;
   assign mem_addr    = I_INSTRUCTION_OR_DATA ? alu_out_reg : pc_reg;
   assign opcode      = ir_reg[31:26];
   assign op_function = ir_reg[5:0];
   assign rd          = ir_reg[25:21];
   assign rs          = ir_reg[20:16];
   assign rt          = ir_reg[15:11];
   assign imm_sext    = {{(DATA_W-16){ir_reg[15]}}, ir_reg[15:0]};

endmodule

// File: tb/tb_fetch_register_bank.sv
// Directed bench for fetch_register_bank: stimulus pushes expected post-edge state, a negedge monitor checks it.
module tb_fetch_register_bank;

   localparam int DATA_W = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0010;

   logic              clk;
   logic              reset;
   logic [31:0]       mem_rdata;
   logic [31:0]       alu_result;
   logic              alu_zero;
   logic              I_PC_WRITE;
   logic              I_BRANCH;
   logic [1:0]        I_PC_SRC;
   logic              I_IR_WRITE;
   logic              I_INSTRUCTION_OR_DATA;
   logic [31:0]       mem_addr;
   logic [31:0]       pc;
   logic [5:0]        opcode;
   logic [5:0]        op_function;
   logic [4:0]        rd;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [31:0]       imm_sext;
   logic [31:0]       mdr;
   logic [31:0]       alu_out;
   logic [31:0]       instr_count;

   fetch_register_bank #(.DATA_W(DATA_W), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .alu_result(alu_result),
      .alu_zero(alu_zero), .I_PC_WRITE(I_PC_WRITE), .I_BRANCH(I_BRANCH),
      .I_PC_SRC(I_PC_SRC), .I_IR_WRITE(I_IR_WRITE),
      .I_INSTRUCTION_OR_DATA(I_INSTRUCTION_OR_DATA), .mem_addr(mem_addr), .pc(pc),
      .opcode(opcode), .op_function(op_function), .rd(rd), .rs(rs), .rt(rt),
      .imm_sext(imm_sext), .mdr(mdr), .alu_out(alu_out), .instr_count(instr_count)
   );

   typedef struct {
      int          edge_no;
      string       tag;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] mdr;
      logic [31:0] alu_out;
      logic [31:0] mem_addr;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   logic [31:0] m_pc, m_ir, m_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic compare_state(input exp_t e);
      logic [31:0] sx;
      sx = {{16{e.ir[15]}}, e.ir[15:0]};
      chk({e.tag, ".pc"}, pc, e.pc);
      chk({e.tag, ".opcode"}, {26'd0, opcode}, {26'd0, e.ir[31:26]});
      chk({e.tag, ".op_function"}, {26'd0, op_function}, {26'd0, e.ir[5:0]});
      chk({e.tag, ".rd"}, {27'd0, rd}, {27'd0, e.ir[25:21]});
      chk({e.tag, ".rs"}, {27'd0, rs}, {27'd0, e.ir[20:16]});
      chk({e.tag, ".rt"}, {27'd0, rt}, {27'd0, e.ir[15:11]});
      chk({e.tag, ".imm_sext"}, imm_sext, sx);
      chk({e.tag, ".mdr"}, mdr, e.mdr);
      chk({e.tag, ".alu_out"}, alu_out, e.alu_out);
      chk({e.tag, ".mem_addr"}, mem_addr, e.mem_addr);
      chk({e.tag, ".instr_count"}, instr_count, e.cnt);
      $display("txn %-10s pc=%h ir=%h mdr=%h alu_out=%h mem_addr=%h cnt=%0d",
               e.tag, pc, e.ir, mdr, alu_out, mem_addr, instr_count);
   endtask

   // Monitor: the registers present their new state one edge after the stimulus.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         if (sb_q[0].edge_no == edge_cnt) begin
            compare_state(sb_q.pop_front());
         end else if (sb_q[0].edge_no < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL monitor_missed %s: edge %0d now %0d", sb_q[0].tag, sb_q[0].edge_no, edge_cnt);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic step(input string tag, input logic [31:0] rdata, input logic [31:0] ares,
                       input logic zero, input logic pcw, input logic br, input logic [1:0] src,
                       input logic irw, input logic iod,
                       input logic [31:0] exp_pc, input logic [31:0] exp_ir);
      exp_t e;
      @(negedge clk);
      #1;
      mem_rdata = rdata; alu_result = ares; alu_zero = zero;
      I_PC_WRITE = pcw; I_BRANCH = br; I_PC_SRC = src; I_IR_WRITE = irw;
      I_INSTRUCTION_OR_DATA = iod;
      m_pc = exp_pc;
      m_ir = exp_ir;
`ifdef IFETCH_PERF_CNT_EN
      if (irw) m_cnt = m_cnt + 32'd1;
`else
      m_cnt = 32'd0;
`endif
      e.edge_no = edge_cnt + 1;
      e.tag = tag;
      e.pc = m_pc; e.ir = m_ir; e.mdr = rdata; e.alu_out = ares;
      e.mem_addr = iod ? ares : m_pc;
      e.cnt = m_cnt;
      sb_q.push_back(e);
   endtask

   task automatic idle_controls();
      I_PC_WRITE = 1'b0; I_BRANCH = 1'b0; I_PC_SRC = 2'b00; I_IR_WRITE = 1'b0;
      I_INSTRUCTION_OR_DATA = 1'b0; alu_zero = 1'b0;
   endtask

   task automatic reset_check(input string tag);
      exp_t e;
      e.edge_no = edge_cnt; e.tag = tag;
      e.pc = RST_PC; e.ir = 32'd0; e.mdr = 32'd0; e.alu_out = 32'd0;
      e.mem_addr = RST_PC; e.cnt = 32'd0;
      compare_state(e);
      m_pc = RST_PC; m_ir = 32'd0; m_cnt = 32'd0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      reset = 1'b1;
      mem_rdata = '0; alu_result = '0;
      idle_controls();
      m_pc = RST_PC; m_ir = 0; m_cnt = 0;

      // Asynchronous assertion, checked before the first rising edge.
      #3 reset = 1'b0;
      #1 reset_check("reset");
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;

      step("hold",     32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h10, 32'h0);
      step("fetch",    32'h4022_1800, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h11, 32'h4022_1800);
      step("ld_aluo",  32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h11, 32'h4022_1800);
      step("bne_nt",   32'h0000_0001, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h11, 32'h4022_1800);
      step("bne_t",    32'h0000_0002, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h20, 32'h4022_1800);
      step("pcw_br",   32'h0000_0003, 32'h0000_0033, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h33, 32'h4022_1800);
      step("j_fetch",  32'h0400_0123, 32'hFC00_0005, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'hFC00_0005, 32'h0400_0123);
      step("jump",     32'h0000_0004, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hFC00_0123, 32'h0400_0123);
      step("reserved", 32'h0000_0005, 32'h0000_0099, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'hFC00_0123, 32'h0400_0123);
      step("neg_imm",  32'h8C43_FFFC, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'hFC00_0123, 32'h8C43_FFFC);
      step("ir_br",    32'h1234_ABCD, 32'h0000_0066, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h55, 32'h1234_ABCD);
      step("br_src0",  32'h0000_0006, 32'h0000_0077, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h77, 32'h1234_ABCD);
      drain();

      // Reset in the middle of a fetch cycle: the pending PC/IR load must not survive.
      mem_rdata = 32'hFFFF_FFFF; alu_result = 32'h0000_0999;
      I_PC_WRITE = 1'b1; I_IR_WRITE = 1'b1; I_PC_SRC = 2'b00; I_INSTRUCTION_OR_DATA = 1'b0;
      #2 reset = 1'b0;
      #1 reset_check("mid_reset");
      @(negedge clk);
      #1 idle_controls();
      reset = 1'b1;

      step("refetch",  32'h4022_1800, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h11, 32'h4022_1800);
      drain();

`ifdef IFETCH_PERF_CNT_EN
      force dut.instr_count_reg = 32'hFFFF_FFFF;
      #1 release dut.instr_count_reg;
      m_cnt = 32'hFFFF_FFFF;
      step("cnt_wrap", 32'h0000_0000, 32'h0000_0012, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h11, 32'h0000_0000);
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_register_bank.md
# fetch_register_bank

Architectural register stage between unified memory, the multicycle control FSM and the ALU datapath. Holds the program counter, instruction register, memory data register and ALU output register. Resolves PC update enables from the FSM's PC_WRITE/BRANCH/PC_SRC controls. Decodes IR fields into the opcode/op_function bus that drives the FSM.

## Interface
- DATA_W, 32, datapath and PC width (≥ 27)
- RESET_PC, 0, PC value loaded on reset (word address)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- mem_rdata  in  DATA_W  read data from unified memory
- alu_result  in  DATA_W  combinational ALU result
- alu_zero  in  1  ALU zero flag for the current cycle
- I_PC_WRITE  in  1  unconditional PC load
- I_BRANCH  in  1  conditional PC load (BNE)
- I_PC_SRC  in  2  PC source select
- I_IR_WRITE  in  1  instruction register load
- I_INSTRUCTION_OR_DATA  in  1  memory address select: 0 = PC, 1 = ALU output register
- mem_addr  out  DATA_W  memory address, combinational
- pc  out  DATA_W  current PC
- opcode  out  6  IR[31:26]
- op_function  out  6  IR[5:0]
- rd, rs, rt  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- imm_sext  out  DATA_W  IR[15:0] sign-extended
- mdr  out  DATA_W  memory data register
- alu_out  out  DATA_W  ALU output register
- instr_count  out  32  retired-fetch counter (0 when IFETCH_PERF_CNT_EN is undefined)

## Operation
- pc_en = I_PC_WRITE | (I_BRANCH & ~alu_zero). BNE branches when operands differ.
- PC next-value mux on I_PC_SRC:
  - 00 → alu_result (PC+1 computed by ALU)
  - 01 → alu_out (branch target registered in decode)
  - 10 → {pc[DATA_W-1:26], IR[25:0]} (jump)
  - 11 → reserved; PC holds even when pc_en = 1
- IR loads mem_rdata when I_IR_WRITE = 1; otherwise holds.
- mdr loads mem_rdata every cycle.
- alu_out loads alu_result every cycle.
- mem_addr = I_INSTRUCTION_OR_DATA ? alu_out : pc.
- Field outputs are combinational from IR. After reset IR = 0, so opcode = 000000 (NOOP) and the FSM sees a harmless instruction.
- PC is loaded, never incremented internally. Arithmetic wraps naturally mod 2^DATA_W.

## Timing
- On reset assertion, immediately and asynchronously: pc = RESET_PC; IR, mdr, alu_out and instr_count = 0; all field outputs 0; mem_addr = RESET_PC.
- Reset mid-instruction abandons the instruction; no partial PC update survives.
- Deassertion takes effect at the first rising edge with reset = 1.
- All register updates occur on the rising edge using the controls sampled at that edge. New values are visible one cycle later.
- Fetch cycle, with I_IR_WRITE = 1, I_PC_WRITE = 1, PC_SRC = 00 and ALU computing PC+1: IR and PC both update on the same edge. IR receives the instruction at the old PC.
- Simultaneous I_PC_WRITE and I_BRANCH: the PC loads regardless of alu_zero.
- I_BRANCH with alu_zero = 1: the PC holds.
- Simultaneous I_IR_WRITE and a PC load are independent; both occur.
- Latency:
  - mem_rdata → opcode: 1 edge.
  - alu_result → alu_out: 1 edge.
  - alu_zero → pc: same edge, no pipeline.

## Configuration
- IFETCH_PERF_CNT_EN defined:
  - A 32-bit instr_count increments on every edge with I_IR_WRITE = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- IFETCH_PERF_CNT_EN undefined: no counter register; instr_count is tied to 0.

## Test plan
- Reset: drive reset = 0 mid-cycle with RESET_PC = 0x10 → pc = 0x10, opcode = 0, mem_addr = 0x10 immediately, before any clock edge. Release → values hold until controls act.
- Fetch:
  - Stimulus: mem_rdata = 0x4022_1800 (MOV), alu_result = 0x11, I_IR_WRITE = I_PC_WRITE = 1, PC_SRC = 00, one edge.
  - Response: opcode = 010000, rd = 1, rs = 2, rt = 3, pc = 0x11, instr_count = 1 (with EN).
- BNE:
  - Stimulus: alu_out = 0x20, I_BRANCH = 1, PC_SRC = 01. First alu_zero = 1, then alu_zero = 0.
  - Response: PC holds, then becomes 0x20.
- Jump: pc = 0xFC00_0005, IR = 0x0400_0123 (J), I_PC_WRITE = 1, PC_SRC = 10 → pc = 0xFC00_0123.
- Reserved select / address mux:
  - PC_SRC = 11 with I_PC_WRITE = 1 → pc unchanged.
  - I_INSTRUCTION_OR_DATA = 1 with alu_out = 0x40 → mem_addr = 0x40.
  - mdr follows mem_rdata one edge later.
- Counter wrap: preload instr_count to 0xFFFFFFFF (via 2^32 fetches in fast sim, or force), one IR write → 0. Build without the macro → instr_count stays 0.
